// File: rtl/mult32x32_pkg.sv
// Shared types and fixed geometry for the mult32x32 sequencer.
// The a-operand is split into 4 bytes and the b-operand into 2 halfwords, giving 8 partial-product steps.
package mult32x32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        MULT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_A_BYTES  = 4;
    localparam int NUM_B_HALVES = 2;
    localparam int NUM_STEPS    = NUM_A_BYTES * NUM_B_HALVES;
    localparam int STEP_W       = 3;

    // Byte shift of a partial product: a byte weight plus twice the b halfword weight.
    function automatic logic [2:0] shift_of(input logic [1:0] a_sel, input logic b_sel);
        return {1'b0, a_sel} + {1'b0, b_sel, 1'b0};
    endfunction

endpackage

// File: rtl/mult32x32_ctrl_if.sv
// Control bus between a requester and the mult32x32 sequencer.
// Master: the requester, which drives start and a_byte_nz. Slave: the sequencer, which drives the arith controls.
interface mult32x32_ctrl_if;
    logic       start;
    logic [3:0] a_byte_nz;
    logic       busy;
    logic       done;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [2:0] shift_sel;
    logic       upd_prod;
    logic       clr_prod;

    modport master (
        output start, a_byte_nz,
        input  busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
    );

    modport slave (
        input  start, a_byte_nz,
        output busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod
    );
endinterface

// File: rtl/mult32x32_ctrl.sv
// Sequencing FSM for mult32x32_arith: clears the product, then runs 8 byte-by-halfword steps, then pulses done.
// Define MULT32X32_CTRL_ZERO_SKIP_EN to skip the steps whose a byte is zero.
module mult32x32_ctrl
    import mult32x32_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    mult32x32_ctrl_if.slave ctrl
);

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_nxt;

`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
    logic [3:0] nz_q;
    logic [3:0] nz_nxt;
    logic [3:0] cand;

    // Returns the lowest step >= from whose a byte is nonzero.
    // Returns 8 when no such step exists.
    function automatic logic [3:0] seek(input logic [3:0] from, input logic [3:0] nz);
        logic [3:0] r;
        r = 4'd8;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (4'(i) >= from && nz[2'(i)]) r = 4'(i);
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
        nz_nxt    = nz_q;
        cand      = 4'd8;
`endif
        case (state)
            IDLE, DONE: begin
                step_nxt = '0;
                if (ctrl.start) begin
                    state_nxt = CLEAR;
`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
                    nz_nxt    = ctrl.a_byte_nz;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
                cand      = seek(4'd0, nz_q);
                state_nxt = cand[3] ? DONE : MULT;
                step_nxt  = cand[3] ? '0 : cand[STEP_W-1:0];
`else
                state_nxt = MULT;
                step_nxt  = '0;
`endif
            end
            MULT: begin
`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
                cand      = seek({1'b0, step} + 4'd1, nz_q);
                state_nxt = cand[3] ? DONE : MULT;
                step_nxt  = cand[3] ? '0 : cand[STEP_W-1:0];
`else
                if (step == STEP_W'(NUM_STEPS - 1)) begin
                    state_nxt = DONE;
                    step_nxt  = '0;
                end else begin
                    step_nxt  = step + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state and step, so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            step           <= '0;
`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
            nz_q           <= '0;
`endif
            ctrl.busy      <= 1'b0;
            ctrl.done      <= 1'b0;
            ctrl.clr_prod  <= 1'b0;
            ctrl.upd_prod  <= 1'b0;
            ctrl.a_sel     <= '0;
            ctrl.b_sel     <= 1'b0;
            ctrl.shift_sel <= '0;
        end else begin
            state          <= state_nxt;
            step           <= step_nxt;
`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
            nz_q           <= nz_nxt;
`endif
            ctrl.busy      <= (state_nxt == CLEAR) || (state_nxt == MULT);
            ctrl.done      <= (state_nxt == DONE);
            ctrl.clr_prod  <= (state_nxt == CLEAR);
            ctrl.upd_prod  <= (state_nxt == MULT);
            ctrl.a_sel     <= (state_nxt == MULT) ? step_nxt[1:0] : 2'd0;
            ctrl.b_sel     <= (state_nxt == MULT) ? step_nxt[2] : 1'b0;
            ctrl.shift_sel <= (state_nxt == MULT) ? shift_of(step_nxt[1:0], step_nxt[2]) : 3'd0;
        end
    end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Directed bench for mult32x32_ctrl with a behavioural arith model that accumulates the product.
// Expected timing follows MULT32X32_CTRL_ZERO_SKIP_EN when it is defined.
module tb_mult32x32_ctrl;
    import mult32x32_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mult32x32_ctrl_if bus ();

    mult32x32_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [63:0] prod = '0;
    logic [7:0]  a_byte;
    logic [15:0] b_half;

    assign a_byte = 8'(op_a >> {bus.a_sel, 3'b000});
    assign b_half = 16'(op_b >> {bus.b_sel, 4'b0000});

    always @(posedge clk) begin
        if (bus.clr_prod)
            prod <= '0;
        else if (bus.upd_prod)
            prod <= prod + ((64'(a_byte) * 64'(b_half)) << {bus.shift_sel, 3'b000});
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {bus.busy, bus.done, bus.a_sel, bus.b_sel, bus.shift_sel, bus.upd_prod, bus.clr_prod};
    endfunction

    // Expected values for full runs and for a=0x000000FF (nz=0001) and a=0 (nz=0000).
    localparam logic [23:0] SH_FULL = 24'o01232345;
    localparam logic [23:0] AB_FULL = 24'o02461357;
`ifdef MULT32X32_CTRL_ZERO_SKIP_EN
    localparam int          LAT_NZ1 = 3;
    localparam int          UPD_NZ1 = 2;
    localparam logic [23:0] SH_NZ1  = 24'o02;
    localparam logic [23:0] AB_NZ1  = 24'o01;
    localparam int          LAT_NZ0 = 1;
    localparam int          UPD_NZ0 = 0;
    localparam logic [23:0] SH_NZ0  = 24'o0;
    localparam logic [23:0] AB_NZ0  = 24'o0;
`else
    localparam int          LAT_NZ1 = 9;
    localparam int          UPD_NZ1 = 8;
    localparam logic [23:0] SH_NZ1  = SH_FULL;
    localparam logic [23:0] AB_NZ1  = AB_FULL;
    localparam int          LAT_NZ0 = 9;
    localparam int          UPD_NZ0 = 8;
    localparam logic [23:0] SH_NZ0  = SH_FULL;
    localparam logic [23:0] AB_NZ0  = AB_FULL;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation. Edge E0 samples start, and latency counts edges from E0 to the first cycle with done high.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] nz, input logic hold,
                          input logic [63:0] exp_prod, input int exp_lat, input int exp_upd,
                          input logic [23:0] exp_sh, input logic [23:0] exp_ab);
        int          done_at;
        int          upd_n;
        int          clr_n;
        logic [23:0] sh;
        logic [23:0] ab;
        op_a          = a;
        op_b          = b;
        bus.a_byte_nz = nz;
        bus.start     = 1'b1;
        tick();
        bus.start = hold;
        done_at   = -1;
        upd_n     = 0;
        clr_n     = 0;
        sh        = '0;
        ab        = '0;
        check({tag, " clear_busy"}, 64'({bus.clr_prod, bus.busy}), 64'b11);
        for (int k = 0; k < 20 && done_at < 0; k++) begin
            if (k > 0) tick();
            if (bus.clr_prod) clr_n++;
            if (bus.upd_prod) begin
                upd_n++;
                sh = {sh[20:0], bus.shift_sel};
                ab = {ab[20:0], bus.a_sel, bus.b_sel};
            end
            if (bus.done) done_at = k;
        end
        check({tag, " latency"}, 64'(done_at), 64'(exp_lat));
        check({tag, " clr_cycles"}, 64'(clr_n), 64'd1);
        check({tag, " upd_cycles"}, 64'(upd_n), 64'(exp_upd));
        check({tag, " shift_seq"}, 64'(sh), 64'(exp_sh));
        check({tag, " sel_seq"}, 64'(ab), 64'(exp_ab));
        check({tag, " product"}, prod, exp_prod);
        check({tag, " done_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int pulses;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.a_byte_nz = '0;

        // Reset held for 4 cycles, then released.
        repeat (4) tick();
        check("rst_outs", 64'(outs()), 64'd0);
        #2 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done || bus.busy) pulses++;
        end
        check("idle_quiet", 64'(pulses), 64'd0);
        check("idle_state", 64'(dut.state), 64'(IDLE));
        check("idle_outs", 64'(outs()), 64'd0);

        // Single operation.
        run_op("op_ff", 32'h0000_00FF, 32'hFFFF_0000, 4'b0001, 1'b0,
               64'h0000_00FE_FF01_0000, LAT_NZ1, UPD_NZ1, SH_NZ1, AB_NZ1);
        tick();
        check("after_done_outs", 64'(outs()), 64'd0);
        check("after_done_state", 64'(dut.state), 64'(IDLE));

        // Start held high, so the next operation restarts directly from DONE.
        run_op("bb1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 1'b1,
               64'hFFFF_FFFE_0000_0001, 9, 8, SH_FULL, AB_FULL);
        run_op("bb2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 1'b1,
               64'hFFFF_FFFE_0000_0001, 9, 8, SH_FULL, AB_FULL);
        bus.start = 1'b0;
        tick();
        check("bb_end_state", 64'(dut.state), 64'(IDLE));

        // Asynchronous reset in MULT step 4 abandons the operation.
        op_a          = 32'hFFFF_FFFF;
        op_b          = 32'hFFFF_FFFF;
        bus.a_byte_nz = 4'b1111;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("step4_sel", 64'({bus.upd_prod, bus.a_sel, bus.b_sel}), 64'b1_00_1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_outs", 64'(outs()), 64'd0);
        check("async_rst_state", 64'(dut.state), 64'(IDLE));
        tick();
        #2 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) pulses++;
        end
        check("no_done_after_rst", 64'(pulses), 64'd0);
        run_op("op_3x5", 32'd3, 32'd5, 4'b0001, 1'b0, 64'd15, LAT_NZ1, UPD_NZ1, SH_NZ1, AB_NZ1);
        tick();

        // All a bytes zero.
        run_op("op_zero", 32'd0, 32'h1234_5678, 4'b0000, 1'b0, 64'd0, LAT_NZ0, UPD_NZ0, SH_NZ0, AB_NZ0);
        tick();
        check("final_outs", 64'(outs()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
